// File: rtl/conv_pkg.sv
// Shared constants and state encoding for the convolution datapath.
// Used by the row scheduler, RF selector and MAC array.
package conv_pkg;

    localparam int ROW_IDX_W    = 6;
    localparam int CONV_H       = 48;
    localparam int CONV_W       = 48;
    localparam int CONV_F       = 5;
    localparam int CONV_SETTLE  = 2;
    localparam int CONV_TIMEOUT = 1024;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SETTLE = 3'd1,
        S_LOAD   = 3'd2,
        S_CONV   = 3'd3,
        S_EMIT   = 3'd4,
        S_FINISH = 3'd5
    } conv_sched_state_t;

endpackage

// File: rtl/conv_settle_timer.sv
// Loadable down-counter with zero flag.
// Times the selector settle window and, optionally, the MAC timeout.
module conv_settle_timer #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_val,
    input  logic             i_en,
    output logic             o_zero
);

    logic [WIDTH-1:0] r_cnt;

    // Load has priority; decrement stops at zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_en && (r_cnt != '0)) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/conv_row_scheduler.sv
// Row-by-row sequencer for one convolution layer.
// Optional MAC watchdog: define CONV_TIMEOUT_EN.
module conv_row_scheduler
    import conv_pkg::*;
#(
    parameter int H       = CONV_H,
    parameter int W       = CONV_W,
    parameter int F       = CONV_F,
    parameter int SETTLE  = CONV_SETTLE,
    parameter int TIMEOUT = CONV_TIMEOUT
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    output logic                 busy,
    output logic                 done,
    output logic [ROW_IDX_W-1:0] row_number,
    output logic                 rf_load,
    output logic                 conv_start,
    input  logic                 conv_done,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [ROW_IDX_W-1:0] out_row
`ifdef CONV_TIMEOUT_EN
    ,
    output logic                 timeout_err
`endif
);

    localparam int OUT_W = W - F + 1;
    localparam logic [ROW_IDX_W-1:0] LAST_ROW = ROW_IDX_W'(H - F);
`ifdef CONV_TIMEOUT_EN
    localparam int TMR_W = ($clog2(TIMEOUT) + 1 > 4) ? $clog2(TIMEOUT) + 1 : 4;
`else
    localparam int TMR_W = 4;
`endif

    if ((H - F + 1) > (1 << ROW_IDX_W) || (H - F + 1) < 1 || OUT_W < 1 ||
        SETTLE < 1 || SETTLE > 15 || TIMEOUT < 1) begin : g_param_err
        $error("conv_row_scheduler: illegal H/W/F/SETTLE/TIMEOUT");
    end

    conv_sched_state_t     r_state;
    logic [ROW_IDX_W-1:0]  r_row;
    logic                  r_busy;
    logic                  r_done;
    logic                  r_rf_load;
    logic                  r_conv_start;
    logic                  r_out_valid;
`ifdef CONV_TIMEOUT_EN
    logic                  r_timeout_err;
`endif

    logic                  w_tmr_load;
    logic                  w_tmr_en;
    logic                  w_tmr_zero;
    logic [TMR_W-1:0]      w_tmr_val;

    // Timer reload at each window start; counts down in SETTLE (and CONV).
    always_comb begin
        w_tmr_load = 1'b0;
        w_tmr_en   = 1'b0;
        w_tmr_val  = TMR_W'(SETTLE - 1);
        unique case (r_state)
            S_IDLE:   w_tmr_load = start;
            S_SETTLE: w_tmr_en   = 1'b1;
            S_EMIT:   w_tmr_load = out_ready && (r_row != LAST_ROW);
`ifdef CONV_TIMEOUT_EN
            S_LOAD: begin
                w_tmr_load = 1'b1;
                w_tmr_val  = TMR_W'(TIMEOUT - 1);
            end
            S_CONV:   w_tmr_en   = 1'b1;
`endif
            default: ;
        endcase
    end

    conv_settle_timer #(
        .WIDTH(TMR_W)
    ) u_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_load    (w_tmr_load),
        .i_load_val(w_tmr_val),
        .i_en      (w_tmr_en),
        .o_zero    (w_tmr_zero)
    );

    // Sequencer with registered strobes; conv_start marks the first CONV cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_row         <= '0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_rf_load     <= 1'b0;
            r_conv_start  <= 1'b0;
            r_out_valid   <= 1'b0;
`ifdef CONV_TIMEOUT_EN
            r_timeout_err <= 1'b0;
`endif
        end else begin
            r_done       <= 1'b0;
            r_rf_load    <= 1'b0;
            r_conv_start <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state       <= S_SETTLE;
                        r_row         <= '0;
                        r_busy        <= 1'b1;
`ifdef CONV_TIMEOUT_EN
                        r_timeout_err <= 1'b0;
`endif
                    end
                end
                S_SETTLE: begin
                    if (w_tmr_zero) begin
                        r_state   <= S_LOAD;
                        r_rf_load <= 1'b1;
                    end
                end
                S_LOAD: begin
                    r_state      <= S_CONV;
                    r_conv_start <= 1'b1;
                end
                S_CONV: begin
                    if (!r_conv_start && conv_done) begin
                        r_state     <= S_EMIT;
                        r_out_valid <= 1'b1;
                    end
`ifdef CONV_TIMEOUT_EN
                    else if (w_tmr_zero) begin
                        r_state       <= S_FINISH;
                        r_done        <= 1'b1;
                        r_timeout_err <= 1'b1;
                    end
`endif
                end
                S_EMIT: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        if (r_row == LAST_ROW) begin
                            r_state <= S_FINISH;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= S_SETTLE;
                            r_row   <= r_row + 1'b1;
                        end
                    end
                end
                S_FINISH: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign busy        = r_busy;
    assign done        = r_done;
    assign row_number  = r_row;
    assign out_row     = r_row;
    assign rf_load     = r_rf_load;
    assign conv_start  = r_conv_start;
    assign out_valid   = r_out_valid;
`ifdef CONV_TIMEOUT_EN
    assign timeout_err = r_timeout_err;
`endif

endmodule

// File: tb/tb_conv_row_scheduler.sv
// Bench for conv_row_scheduler: timeline reference model plus scenario checks.
// Timeout scenario is built only when CONV_TIMEOUT_EN is defined.
module tb_conv_row_scheduler;
    import conv_pkg::*;

    localparam int H       = 8;
    localparam int F       = 5;
    localparam int SETTLE  = 2;
    localparam int TIMEOUT = 16;
    localparam int LAST    = H - F;
`ifdef CONV_TIMEOUT_EN
    localparam bit TMO_ON  = 1'b1;
`else
    localparam bit TMO_ON  = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       conv_done = 1'b0;
    logic       out_ready = 1'b0;
    logic       busy, done, rf_load, conv_start, out_valid;
    logic [5:0] row_number, out_row;
    logic       terr;

    conv_row_scheduler #(
        .H(H), .W(8), .F(F), .SETTLE(SETTLE), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .busy       (busy),
        .done       (done),
        .row_number (row_number),
        .rf_load    (rf_load),
        .conv_start (conv_start),
        .conv_done  (conv_done),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_row    (out_row)
`ifdef CONV_TIMEOUT_EN
        ,
        .timeout_err(terr)
`endif
    );

`ifndef CONV_TIMEOUT_EN
    assign terr = 1'b0;
`endif

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int cyc = 0;

    // reference model: expected event times, in cycle numbers
    int m_busy = 0, m_row = 0, m_valid = 0, m_terr = 0;
    int m_load_at = -1, m_cs_at = -1, m_done_at = -1;

    // stimulus control
    int cd_mode = 0, cd_delay = 3, rdy_mode = 0;
    int cs_cyc = -100, hold = 0;

    // monitors
    int n_rf = 0, n_cs = 0, n_done = 0, rc_ok = 0, two_ok = 0;
    int first_rf = -1, last_rf = -100, last_cs = -100, last_done = -1;
    int acc1 = -1, rf_after = -1, st_cyc = 0;
    bit prev_valid = 0;
    int rows_q[$];

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic clr();
        n_rf = 0; n_cs = 0; n_done = 0; rc_ok = 0; two_ok = 0;
        first_rf = -1; acc1 = -1; rf_after = -1; hold = 0;
        rows_q.delete();
    endtask

    // model advance at each rising edge from the inputs seen at that edge
    always @(posedge clk) begin
        if (!rst_n) begin
            m_busy = 0; m_row = 0; m_valid = 0; m_terr = 0;
            m_load_at = -1; m_cs_at = -1; m_done_at = -1;
        end else begin
            int n;
            bit st, cd, tmo, ld, acc, fin;
            n   = cyc;
            st  = !m_busy && start;
            cd  = (m_cs_at >= 0) && (n > m_cs_at) && conv_done;
            tmo = TMO_ON && (m_cs_at >= 0) && !cd && (n - m_cs_at + 1 >= TIMEOUT);
            ld  = (n == m_load_at);
            acc = m_valid && out_ready;
            fin = (n == m_done_at);
            if (st) begin
                m_busy = 1; m_row = 0; m_terr = 0;
                m_load_at = n + 1 + SETTLE;
            end
            if (ld) m_cs_at = n + 1;
            if (cd) begin
                m_cs_at = -1; m_valid = 1;
            end else if (tmo) begin
                m_cs_at = -1; m_terr = 1; m_done_at = n + 1;
            end
            if (acc) begin
                m_valid = 0;
                if (m_row == LAST) m_done_at = n + 1;
                else begin
                    m_row++;
                    m_load_at = n + 1 + SETTLE;
                end
            end
            if (fin) m_busy = 0;
        end
        cyc++;
    end

    // per-cycle compare, monitors, then drive conv_done/out_ready
    always @(negedge clk) begin
        if (rst_n) begin
            logic [17:0] exp_v, act_v;
            exp_v = {m_busy[0], cyc == m_done_at, cyc == m_load_at,
                     cyc == m_cs_at, m_valid[0], 6'(m_row), 6'(m_row),
                     TMO_ON ? m_terr[0] : 1'b0};
            act_v = {busy, done, rf_load, conv_start, out_valid,
                     row_number, out_row, terr};
            total++;
            if (act_v !== exp_v) begin
                bad++;
                $display("FAIL cycle%0d outputs: got %b expected %b",
                         cyc, act_v, exp_v);
            end
            if (rf_load) begin
                n_rf++; last_rf = cyc;
                if (first_rf < 0) first_rf = cyc;
                if (acc1 >= 0 && rf_after < 0) rf_after = cyc - acc1;
            end
            if (conv_start) begin
                n_cs++; cs_cyc = cyc;
                if (cyc == last_rf + 1) rc_ok++;
                last_cs = cyc;
            end
            if (done) begin
                n_done++; last_done = cyc;
            end
            if (out_valid && !prev_valid && cyc - last_cs == 2) two_ok++;
            prev_valid = out_valid;
            unique case (cd_mode)
                0: conv_done = (cyc == cs_cyc + cd_delay);
                1: conv_done = 1'b1;
                2: conv_done = ($urandom_range(0, 3) == 0);
                default: conv_done = 1'b0;
            endcase
            unique case (rdy_mode)
                0: out_ready = 1'b1;
                1: out_ready = $urandom_range(0, 1) == 1;
                default: begin
                    if (out_valid && out_row == 6'd1 && hold < 5) begin
                        out_ready = 1'b0; hold++;
                    end else begin
                        out_ready = 1'b1;
                    end
                end
            endcase
            if (out_valid && out_ready) begin
                rows_q.push_back(int'(out_row));
                if (out_row == 6'd1) acc1 = cyc;
            end
        end
    end

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1; st_cyc = cyc;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int d0;
        d0 = n_done;
        for (int i = 0; i < 3000 && n_done == d0; i++) @(negedge clk);
        if (n_done == d0) chk({name, "_done_timeout"}, 0, 1);
        repeat (2) @(negedge clk);
        chk({name, "_busy_after"}, int'(busy), 0);
    endtask

    task automatic chk_rows(input string name);
        chk({name, "_nrows"}, rows_q.size(), LAST + 1);
        for (int i = 0; i < rows_q.size() && i <= LAST; i++)
            chk({name, "_row"}, rows_q[i], i);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("reset_outputs", int'({busy, done, rf_load, conv_start,
            out_valid, row_number, out_row, terr}), 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // basic layer
        clr(); cd_mode = 0; cd_delay = 3; rdy_mode = 0;
        pulse_start();
        wait_done("basic");
        chk_rows("basic");
        chk("basic_rf_load", n_rf, 4);
        chk("basic_conv_start", n_cs, 4);
        chk("basic_done", n_done, 1);
        chk("basic_first_rf", first_rf - st_cyc, 3);

        // backpressure on row 1
        clr(); rdy_mode = 2;
        pulse_start();
        wait_done("bp");
        chk_rows("bp");
        chk("bp_hold", hold, 5);
        chk("bp_rf_after_accept", rf_after, 3);

        // stale conv_done level
        clr(); cd_mode = 1; rdy_mode = 0;
        pulse_start();
        wait_done("stale");
        chk("stale_two_conv", two_ok, 4);
        chk("stale_rf_to_cs", rc_ok, 4);

        // start pulses while busy at rows 0 and 3
        clr(); cd_mode = 0;
        pulse_start();
        for (int i = 0; i < 200 && !(m_row == 0 && m_cs_at >= 0); i++)
            @(negedge clk);
        pulse_start();
        for (int i = 0; i < 400 && !(m_row == 3 && m_cs_at >= 0); i++)
            @(negedge clk);
        pulse_start();
        wait_done("ign");
        chk_rows("ign");
        chk("ign_done", n_done, 1);

        // async reset mid-CONV on row 2
        clr();
        pulse_start();
        for (int i = 0; i < 400 && !(m_row == 2 && m_cs_at >= 0); i++)
            @(negedge clk);
        chk("rst_reached_row2", row_number, 2);
        #2 rst_n = 1'b0;
        #1 chk("rst_async_outputs", int'({busy, done, rf_load, conv_start,
            out_valid, row_number, out_row, terr}), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        chk("rst_no_done", n_done, 0);
        clr();
        pulse_start();
        wait_done("restart");
        chk_rows("restart");

        // randomized layers
        for (int k = 0; k < 6; k++) begin
            clr(); cd_mode = 2; rdy_mode = 1;
            repeat ($urandom_range(0, 4)) @(negedge clk);
            pulse_start();
            wait_done("rand");
            chk_rows("rand");
            chk("rand_done", n_done, 1);
        end

`ifdef CONV_TIMEOUT_EN
        clr(); cd_mode = 3; rdy_mode = 0;
        pulse_start();
        wait_done("tmo");
        chk("tmo_err", int'(terr), 1);
        chk("tmo_latency", last_done - cs_cyc, 16);
        chk("tmo_rows", rows_q.size(), 0);
        clr(); cd_mode = 0;
        pulse_start();
        chk("tmo_cleared", int'(terr), 0);
        wait_done("tmo_next");
        chk_rows("tmo_next");
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
